// File: rtl/funds_display_driver_if.sv
`default_nettype none
// ============================================================================
// funds_display_driver_if
// Bundle of the conversion request, BCD result and 7-segment scan signals
// shared between a value source (master) and funds_display_driver (slave).
// Revision: 1.0
// ============================================================================
interface funds_display_driver_if #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
);
  logic [WIDTH-1:0]    value;
  logic                update;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd;
  logic [6:0]          seg;
  logic [DIGITS-1:0]   digit_sel;

  modport master (
    output value, update,
    input  busy, done, bcd, seg, digit_sel
  );

  modport slave (
    input  value, update,
    output busy, done, bcd, seg, digit_sel
  );
endinterface
`default_nettype wire

// File: rtl/funds_display_driver.sv
`default_nettype none
// ============================================================================
// funds_display_driver
// Sequential double-dabble binary-to-BCD converter (one bit per clock) with a
// continuously running, registered 7-segment digit scanner.
// Optional feature macro: FUNDS_DISPLAY_BLANK_EN (leading-zero blanking).
// Revision: 1.0
// ============================================================================
module funds_display_driver #(
  parameter int WIDTH    = 32,
  parameter int DIGITS   = 10,
  parameter int SCAN_DIV = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  funds_display_driver_if.slave bus
);
  // ceil(WIDTH * log10(2)) using a fixed-point approximation of log10(2)
  localparam int MIN_DIGITS = (WIDTH * 30103 + 99999) / 100000;
  localparam int CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SC_W       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DI_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int TOT        = 4 * DIGITS + WIDTH;
  localparam logic [DIGITS-1:0] SEL_ONE = DIGITS'(1);

  if (DIGITS < MIN_DIGITS) begin : g_digits_check
    $error("funds_display_driver: DIGITS too small for WIDTH");
  end
  if (SCAN_DIV < 1) begin : g_scan_check
    $error("funds_display_driver: SCAN_DIV must be >= 1");
  end

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t              state, state_nx;
  logic                load, step, finish;
  logic [CNT_W-1:0]    cnt;
  logic [TOT-1:0]      work, shifted;
  logic [4*DIGITS-1:0] bcd_adj;
  logic [4*DIGITS-1:0] bcd_r;
  logic                done_r;

  logic [SC_W-1:0]     scan_cnt;
  logic [DI_W-1:0]     digit_idx, idx_nx;
  logic [DIGITS-1:0]   blank;
  logic                run_zero;
  logic [6:0]          seg_r, seg_nx;
  logic [DIGITS-1:0]   sel_r;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h00;
    endcase
  endfunction

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // FSM next-state and datapath control strobes
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.update) begin
          load     = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) begin
          finish   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Add-3 on every nibble >= 5, then shift the whole register left; the bit
  // leaving the top nibble is always zero when DIGITS is large enough
  always_comb begin
    bcd_adj = work[TOT-1:WIDTH];
    for (int i = 0; i < DIGITS; i++) begin
      if (work[WIDTH + 4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = work[WIDTH + 4*i +: 4] + 4'd3;
    end
    shifted = {bcd_adj, work[WIDTH-1:0]} << 1;
  end

  // Conversion shift register, iteration counter and held result
  always_ff @(posedge clk) begin
    if (rst) begin
      work   <= '0;
      cnt    <= '0;
      bcd_r  <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= finish;
      if (load) begin
        work <= {{(4*DIGITS){1'b0}}, bus.value};
        cnt  <= '0;
      end else if (step) begin
        work <= shifted;
        cnt  <= cnt + CNT_W'(1);
      end
      if (finish) bcd_r <= shifted[TOT-1:WIDTH];
    end
  end

  // Leading-zero blank mask from the held result; digit 0 never blanks
  always_comb begin
    blank    = '0;
    run_zero = 1'b1;
`ifdef FUNDS_DISPLAY_BLANK_EN
    for (int i = DIGITS - 1; i > 0; i--) begin
      run_zero = run_zero & (bcd_r[4*i +: 4] == 4'd0);
      blank[i] = run_zero;
    end
`endif
  end

  // Next scan digit and its segment pattern, registered together below
  always_comb begin
    idx_nx = digit_idx;
    if (scan_cnt == SC_W'(SCAN_DIV - 1)) begin
      if (digit_idx == DI_W'(DIGITS - 1)) idx_nx = '0;
      else                                idx_nx = digit_idx + DI_W'(1);
    end
    seg_nx = blank[idx_nx] ? 7'h00 : decode(bcd_r[4*idx_nx +: 4]);
  end

  // Free-running scan divider; seg and digit_sel update on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
      sel_r     <= SEL_ONE;
      seg_r     <= 7'h3F;
    end else begin
      if (scan_cnt == SC_W'(SCAN_DIV - 1)) scan_cnt <= '0;
      else                                 scan_cnt <= scan_cnt + SC_W'(1);
      digit_idx <= idx_nx;
      sel_r     <= SEL_ONE << idx_nx;
      seg_r     <= seg_nx;
    end
  end

  assign bus.busy      = (state == SHIFT);
  assign bus.done      = done_r;
  assign bus.bcd       = bcd_r;
  assign bus.seg       = seg_r;
  assign bus.digit_sel = sel_r;
endmodule
`default_nettype wire
